// File: rtl/data_mem_responder.sv
`timescale 1ns/1ps
// Data memory responder: single-cycle load/store with a held response stage.
// Pipelined accept lets a new request enter while the current response drains.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state_q, state_d;
  logic        accept, req_err, wr_en;
  logic        f3_bad, mis, oob;
  logic [31:0] widx;
  logic [AW-1:0] idx;
  logic [1:0]  lane;
  logic [4:0]  sh;
  logic [31:0] rd_word, ld_data, wmask, wshift;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_ready = (state_q == IDLE) || rsp_ready;
  assign rsp_valid = (state_q == RESP);
  assign accept    = req_valid && req_ready;

  assign widx = {2'b00, req_addr[31:2]};
  assign idx  = req_addr[AW+1:2];
  assign lane = req_addr[1:0];
  assign sh   = {lane, 3'b000};
  assign oob  = widx >= 32'(DEPTH_WORDS);

  assign rd_word = oob ? '0 : mem[idx];
  assign rd_byte = rd_word[sh +: 8];
  assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];
  assign wshift  = req_wdata << sh;

  always_comb begin
    f3_bad  = 1'b0;
    mis     = 1'b0;
    wmask   = '0;
    ld_data = '0;
    unique case (req_funct3)
      3'b000: begin
        wmask   = 32'h0000_00ff << sh;
        ld_data = {{24{rd_byte[7]}}, rd_byte};
      end
      3'b001: begin
        mis     = lane[0];
        wmask   = 32'h0000_ffff << sh;
        ld_data = {{16{rd_half[15]}}, rd_half};
      end
      3'b010: begin
        mis     = |lane;
        wmask   = '1;
        ld_data = rd_word;
      end
      3'b100: begin
        f3_bad  = req_we;
        ld_data = {24'h0, rd_byte};
      end
      3'b101: begin
        f3_bad  = req_we;
        mis     = lane[0];
        ld_data = {16'h0, rd_half};
      end
      default: f3_bad = 1'b1;
    endcase
  end

  assign req_err = f3_bad || mis || oob;
  assign wr_en   = accept && req_we && !req_err;

  // Reset is sampled here so a store on an edge during reset is dropped.
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      mem[idx] <= (rd_word & ~wmask) | (wshift & wmask);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RESP;
      RESP: if (rsp_ready && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rsp_err   <= req_err;
        rsp_rdata <= (req_err || req_we) ? '0 : ld_data;
      end
    end
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words in the data memory.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have port req_valid, input, 1, meaning the core presents a load/store request.
REQ-005 The block SHALL have port req_ready, output, 1, meaning the responder accepts a request this cycle.
REQ-006 The block SHALL have port req_we, input, 1, where 1 means store and 0 means load.
REQ-007 The block SHALL have port req_funct3, input, 3, the RISC-V load/store funct3 code.
REQ-008 The block SHALL have port req_addr, input, 32, the byte address.
REQ-009 The block SHALL have port req_wdata, input, 32, the store data, right-aligned.
REQ-010 The block SHALL have port rsp_valid, output, 1, meaning a response is presented.
REQ-011 The block SHALL have port rsp_ready, input, 1, meaning the core consumes the response.
REQ-012 The block SHALL have port rsp_rdata, output, 32, the extended load data, or 0 for stores and errors.
REQ-013 The block SHALL have port rsp_err, output, 1, flagging a misaligned, out-of-range or illegal-funct3 request.

Function
REQ-014 The block SHALL implement a 2-state FSM: IDLE (no response held) and RESP (response held).
REQ-015 In IDLE, req_ready SHALL be 1; in RESP, req_ready SHALL equal rsp_ready (pipelined accept).
REQ-016 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-017 The response SHALL appear one cycle after acceptance: rsp_valid=1 with rsp_rdata/rsp_err registered.
REQ-018 Transitions SHALL be: IDLE→RESP on accept; RESP→IDLE on rsp_ready and no accept; RESP→RESP on rsp_ready and accept (new response loaded); RESP held unchanged while rsp_ready=0.
REQ-019 rsp_rdata and rsp_err SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-020 The word index SHALL be req_addr[31:2], and the byte lane SHALL be req_addr[1:0].
REQ-021 Load funct3 000/001/010/100/101 (lb/lh/lw/lbu/lhu) SHALL select the addressed byte/half/word; lb/lh SHALL sign-extend and lbu/lhu SHALL zero-extend to 32 bits.
REQ-022 Store funct3 000/001/010 (sb/sh/sw) SHALL write req_wdata[7:0]/[15:0]/[31:0] into the addressed lanes only; the other bytes of the word SHALL be unchanged.
REQ-023 Stores SHALL commit on the accept edge; a load accepted on the next edge to the same address SHALL return the new data.
REQ-024 An error SHALL be raised when any of the following holds: halfword with addr[0]=1; word with addr[1:0]≠00; word index ≥ DEPTH_WORDS; load funct3 011/110/111; store funct3 other than 000/001/010.
REQ-025 An erroring request SHALL be accepted normally, SHALL NOT modify memory, and SHALL respond with rsp_err=1 and rsp_rdata=0.
REQ-026 Store responses SHALL carry rsp_rdata=0 and rsp_err=0 when legal.
REQ-027 Memory array contents SHALL NOT be reset and are undefined until written.

Reset
REQ-028 On reset low, the FSM SHALL go to IDLE asynchronously, with rsp_valid=0, rsp_err=0 and rsp_rdata=0.
REQ-029 A response held when reset asserts SHALL be discarded, and a request on the edge coinciding with reset SHALL NOT write memory.
REQ-030 After reset deasserts, req_ready SHALL be 1 on the first cycle.

Verification
REQ-031 sw 0xDEADBEEF @0x10, then lw @0x10 → second response rsp_rdata=0xDEADBEEF, rsp_err=0, one cycle after accept.
REQ-032 sb 0x80 @0x13, then lb @0x13 → 0xFFFFFF80; lbu @0x13 → 0x00000080; lw @0x10 → 0x80ADBEEF.
REQ-033 lh @0x11 → rsp_err=1, rsp_rdata=0; sw @0x12 → rsp_err=1 and memory word @0x10 unchanged; lw @(DEPTH_WORDS*4) → rsp_err=1.
REQ-034 Hold rsp_ready=0 for 3 cycles with a response pending → rsp_valid/rsp_rdata stable, req_ready=0; release rsp_ready with req_valid=1 → back-to-back accept, FSM stays in RESP.
REQ-035 Assert reset mid-RESP → rsp_valid=0 immediately, without waiting for a clock edge; a store presented on the coinciding edge leaves memory unchanged.
REQ-036 Stream 8 alternating sw/lw with rsp_ready=1 throughout → one response per cycle, with loads returning the previously stored values.
